shift_rx100: RTL and testbench
==============================

Name: shift_rx100

Overview:
- Serial-to-parallel receiver, the receive end of the team's 100-bit rotator.
- Captures one bit per valid cycle, either LSB-first or MSB-first, and reassembles the WIDTH-bit word.
- Presents the word on a valid/ready output handshake.
- Typical source: q[0] of a rotator rotating right (LSB-first) or q[99] of a rotator rotating left (MSB-first).

Parameters:
- WIDTH, 100, word length in bits.
- CNT_W, 7, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- areset  input  1  asynchronous, active-high reset.
- start  input  1  frame start pulse; latches dir and begins a frame.
- dir  input  1  0 = LSB-first, 1 = MSB-first; sampled only when start is accepted.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is a valid bit this cycle.
- q  output  WIDTH  assembled word; stable while q_valid = 1.
- q_valid  output  1  word complete and held.
- q_ready  input  1  consumer accepts q.
- busy  output  1  high in RECV (and PAR when the option is built).
- overrun  output  1  sticky; set when a bit is dropped; cleared only by areset.

Behaviour:
- Reset (asynchronous): state = IDLE, q = 0, counter = 0, dir register = 0, q_valid = 0, busy = 0, overrun = 0.
- State IDLE:
  - start = 1: latch dir, counter = 0, go to RECV.
  - If sin_valid = 1 in the same cycle, that sin is bit 0 of the frame and the counter becomes 1.
  - sin_valid without start: bit ignored, no flag.
- State RECV, each cycle with sin_valid = 1:
  - LSB-first: q <= {sin, q[WIDTH-1:1]}.
  - MSB-first: q <= {q[WIDTH-2:0], sin}.
  - Counter increments.
  - The bit that brings the count to WIDTH moves the block to FULL; q_valid rises the next cycle (1-cycle latency after the last bit).
  - sin_valid = 0: hold q and counter.
- Restart in RECV: start = 1 aborts the current frame. Counter = 0, dir is re-latched, and a same-cycle sin_valid bit counts as the new bit 0. Partial data is discarded silently.
- State FULL:
  - q_valid = 1; q is held.
  - Transfer occurs on q_valid & q_ready, then go to IDLE.
  - If start is also high in the transfer cycle, go directly to RECV with the same-cycle bit rule as IDLE.
  - start without q_ready: ignored.
  - sin_valid = 1 in FULL, except a bit accepted with start in the transfer cycle: bit dropped, overrun = 1.
- Counter: saturates logic at WIDTH; no wrap inside a frame.
- LSB-first vs MSB-first: after exactly WIDTH bits, the first-received bit sits at q[0] (LSB-first) or q[WIDTH-1] (MSB-first).
- q_valid never falls without a transfer. q_valid and busy are never both 1.

Optional Feature:
- Macro: SHIFT_RX_PARITY_EN.
- When defined:
  - Adds state PAR after RECV. The next valid bit after WIDTH data bits is an even-parity bit over the word.
  - Adds output parity_err (1 bit). It is valid with q_valid and equals XOR of q and the parity bit. It resets to 0.
  - busy stays high in PAR.
  - start in PAR aborts the frame, as in RECV.
- When undefined: no PAR state and no parity_err port; RECV goes straight to FULL.

Decomposition:
- Package shift_rx_pkg:
  - State enum: IDLE, RECV, PAR, FULL.
  - Direction constants: DIR_LSB_FIRST = 1'b0, DIR_MSB_FIRST = 1'b1.
  - Default WIDTH and CNT_W constants.
- One sub-module, shift_rx_bitcnt: clear/increment bit counter with a terminal-count flag (count == WIDTH-1 and inc), parameterised by WIDTH and CNT_W.

Test Plan:
- LSB-first round trip:
  - Stimulus: rotator loaded with data = 100'h0F0F_..._1234, ena = 2'b01, feed q[0] for 100 cycles with sin_valid = 1 and start on the first cycle, dir = 0.
  - Required: q == data, with q_valid one cycle after bit 99.
- MSB-first round trip:
  - Stimulus: same data, ena = 2'b10, feed q[99], dir = 1.
  - Required: q == data.
- Backpressure and overrun:
  - Stimulus: hold q_ready = 0 for 20 cycles after q_valid while sin_valid = 1.
  - Required: q unchanged, overrun = 1, q_valid stays 1. Raise q_ready: one transfer, state = IDLE.
- Restart:
  - Stimulus: after 37 bits, pulse start with sin_valid = 1, then send 99 more bits.
  - Required: q_valid only after 100 new-frame bits, and q holds only new-frame bits.
- Async reset mid-frame:
  - Stimulus: assert areset between edges at bit 50.
  - Required: q = 0, q_valid = 0, busy = 0, overrun = 0 immediately, with no clock edge needed.
- Parity (SHIFT_RX_PARITY_EN):
  - Stimulus: word with 3 ones; parity bit 1 -> parity_err = 0; parity bit 0 -> parity_err = 1.

Source files
------------

// File: rtl/shift_rx_pkg.sv
// Shared types and constants for the shift_rx100 serial receiver.
// The PAR state is only entered when SHIFT_RX_PARITY_EN is defined.
package shift_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2,
    FULL = 2'd3
  } state_t;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  localparam int DEFAULT_WIDTH = 100;
  localparam int DEFAULT_CNT_W = 7;

endpackage

// File: rtl/shift_rx_bitcnt.sv
// Bit counter for the serial receiver: clear restarts a frame, inc counts
// one accepted bit. A clear and an inc in the same cycle make that bit the
// first of the new frame. The count saturates at WIDTH so it never wraps.
module shift_rx_bitcnt #(
  parameter int WIDTH = 100,
  parameter int CNT_W = 7
) (
  input  logic clk,
  input  logic areset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_tc
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_base;

  assign w_base = i_clear ? '0 : r_count;
  assign o_tc   = i_inc && (w_base == CNT_W'(WIDTH - 1));

  // Clear and/or count one bit, holding once WIDTH bits have been seen.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_count <= '0;
    end else if (i_inc && (w_base != CNT_W'(WIDTH))) begin
      r_count <= w_base + CNT_W'(1);
    end else begin
      r_count <= w_base;
    end
  end

endmodule

// File: rtl/shift_rx100.sv
// Serial-to-parallel receiver for the 100-bit rotator. Collects WIDTH bits
// LSB-first or MSB-first and holds the word on a valid/ready handshake.
// Optional even-parity bit after the data: define SHIFT_RX_PARITY_EN.
module shift_rx100
  import shift_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             start,
  input  logic             dir,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
`ifdef SHIFT_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun
);

`ifdef SHIFT_RX_PARITY_EN
  localparam state_t DATA_DONE = PAR;
`else
  localparam state_t DATA_DONE = FULL;
`endif

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_q;
  logic             r_dir;
  logic             r_qValid;
  logic             r_busy;
  logic             r_overrun;

  logic             w_startAccept;
  logic             w_shift;
  logic             w_dirUse;
  logic             w_drop;
  logic             w_tc;
  logic [WIDTH-1:0] w_shifted;

  // A start in FULL only counts when the held word is handed off that cycle.
  assign w_startAccept = start && ((r_state != FULL) || q_ready);

  // Data bits shift in while receiving, or as bit 0 of a newly accepted frame.
  assign w_shift = sin_valid && (w_startAccept || (r_state == RECV));

  // Any valid bit arriving while a word is held and no new frame starts is lost.
  assign w_drop = sin_valid && (r_state == FULL) && !w_startAccept;

  // The bit that arrives with start obeys the new direction, not the old one.
  assign w_dirUse  = w_startAccept ? dir : r_dir;
  assign w_shifted = (w_dirUse == DIR_MSB_FIRST) ? {r_q[WIDTH-2:0], sin}
                                                 : {sin, r_q[WIDTH-1:1]};

  shift_rx_bitcnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bitcnt (
    .clk     (clk),
    .areset  (areset),
    .i_clear (w_startAccept),
    .i_inc   (w_shift),
    .o_tc    (w_tc)
  );

  // Next-state decode; an accepted start always wins and (re)opens a frame.
  always_comb begin
    w_nextState = r_state;
    if (w_startAccept) begin
      w_nextState = w_tc ? DATA_DONE : RECV;
    end else begin
      case (r_state)
        RECV: if (w_tc) w_nextState = DATA_DONE;
`ifdef SHIFT_RX_PARITY_EN
        PAR:  if (sin_valid) w_nextState = FULL;
`endif
        FULL: if (q_ready) w_nextState = IDLE;
        default: ;
      endcase
    end
  end

  // State, registered handshake outputs, shift register and sticky overrun.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state   <= IDLE;
      r_q       <= '0;
      r_dir     <= DIR_LSB_FIRST;
      r_qValid  <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_qValid <= (w_nextState == FULL);
      r_busy   <= (w_nextState == RECV) || (w_nextState == PAR);
      if (w_startAccept) r_dir <= dir;
      if (w_shift) r_q <= w_shifted;
      if (w_drop) r_overrun <= 1'b1;
    end
  end

`ifdef SHIFT_RX_PARITY_EN
  logic r_parityErr;

  // Even parity: the data word XOR the trailing parity bit must be zero.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_parityErr <= 1'b0;
    end else if ((r_state == PAR) && sin_valid && !w_startAccept) begin
      r_parityErr <= (^r_q) ^ sin;
    end
  end

  assign parity_err = r_parityErr;
`endif

  assign q       = r_q;
  assign q_valid = r_qValid;
  assign busy    = r_busy;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_shift_rx100.sv
// Directed testbench for shift_rx100. Inputs are driven on the falling edge
// and outputs are checked on the falling edge, away from the active edge.
// Build with SHIFT_RX_PARITY_EN to also exercise the parity option.
module tb_shift_rx100;

  localparam int W = 100;

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         q_ready = 1'b0;
  logic [W-1:0] q;
  logic         q_valid;
  logic         busy;
  logic         overrun;
`ifdef SHIFT_RX_PARITY_EN
  logic         parity_err;
`endif

  int numChecks = 0;
  int numFails  = 0;

  logic [W-1:0] dataA = 100'h0F0F0F0F0F0F0F0F0F0F01234;
  logic [W-1:0] dataB = 100'hA5A5A5A5A5A5A5A5A5A5A5A5A;
  logic [W-1:0] dataC = 100'h3C3C3C3C3C3C3C3C3C3C0BEEF;
  logic [W-1:0] rot;

  shift_rx100 dut (
    .clk        (clk),
    .areset     (areset),
    .start      (start),
    .dir        (dir),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .q          (q),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .busy       (busy),
`ifdef SHIFT_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge.
  task automatic applyStimulus(input logic st, input logic d, input logic s,
                               input logic sv, input logic qr);
    @(negedge clk);
    start     = st;
    dir       = d;
    sin       = s;
    sin_valid = sv;
    q_ready   = qr;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    numChecks++;
    if (q !== '0) begin numFails++; $display("[TB] FAIL reset_q got %h want 0", q); end
    numChecks++;
    if (q_valid !== 1'b0) begin numFails++; $display("[TB] FAIL reset_q_valid got %b want 0", q_valid); end
    numChecks++;
    if (busy !== 1'b0) begin numFails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    numChecks++;
    if (overrun !== 1'b0) begin numFails++; $display("[TB] FAIL reset_overrun got %b want 0", overrun); end
    areset = 1'b0;
  endtask

  // Rotator rotating right, its q[0] feeding the receiver LSB-first.
  task automatic test_lsb_first();
    rot = dataA;
    for (int i = 0; i < W; i++) begin
      applyStimulus(i == 0, 1'b0, rot[0], 1'b1, 1'b0);
      rot = {rot[0], rot[W-1:1]};
      if (q_valid !== 1'b0) begin
        numChecks++; numFails++;
        $display("[TB] FAIL lsb_early_valid bit %0d got %b want 0", i, q_valid);
      end
      if (i == 50) begin
        numChecks++;
        if (busy !== 1'b1) begin numFails++; $display("[TB] FAIL lsb_busy got %b want 1", busy); end
      end
    end
`ifdef SHIFT_RX_PARITY_EN
    applyStimulus(1'b0, 1'b0, ^dataA, 1'b1, 1'b0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    numChecks++;
    if (q_valid !== 1'b1) begin numFails++; $display("[TB] FAIL lsb_q_valid got %b want 1", q_valid); end
    numChecks++;
    if (q !== dataA) begin numFails++; $display("[TB] FAIL lsb_q got %h want %h", q, dataA); end
    numChecks++;
    if (busy !== 1'b0) begin numFails++; $display("[TB] FAIL lsb_full_busy got %b want 0", busy); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    numChecks++;
    if (q_valid !== 1'b0) begin numFails++; $display("[TB] FAIL lsb_transfer got %b want 0", q_valid); end
  endtask

  // Rotator rotating left, its q[99] feeding the receiver MSB-first.
  task automatic test_msb_first();
    rot = dataA;
    for (int i = 0; i < W; i++) begin
      applyStimulus(i == 0, 1'b1, rot[W-1], 1'b1, 1'b0);
      rot = {rot[W-2:0], rot[W-1]};
    end
`ifdef SHIFT_RX_PARITY_EN
    applyStimulus(1'b0, 1'b0, ^dataA, 1'b1, 1'b0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    numChecks++;
    if (q_valid !== 1'b1) begin numFails++; $display("[TB] FAIL msb_q_valid got %b want 1", q_valid); end
    numChecks++;
    if (q !== dataA) begin numFails++; $display("[TB] FAIL msb_q got %h want %h", q, dataA); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < W; i++) begin
      applyStimulus(i == 0, 1'b0, dataB[i], 1'b1, 1'b0);
    end
`ifdef SHIFT_RX_PARITY_EN
    applyStimulus(1'b0, 1'b0, ^dataB, 1'b1, 1'b0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    numChecks++;
    if (overrun !== 1'b0) begin numFails++; $display("[TB] FAIL bp_overrun_early got %b want 0", overrun); end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, i[0], 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    numChecks++;
    if (q !== dataB) begin numFails++; $display("[TB] FAIL bp_q got %h want %h", q, dataB); end
    numChecks++;
    if (q_valid !== 1'b1) begin numFails++; $display("[TB] FAIL bp_q_valid got %b want 1", q_valid); end
    numChecks++;
    if (overrun !== 1'b1) begin numFails++; $display("[TB] FAIL bp_overrun got %b want 1", overrun); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    numChecks++;
    if (q_valid !== 1'b0) begin numFails++; $display("[TB] FAIL bp_transfer got %b want 0", q_valid); end
    numChecks++;
    if (busy !== 1'b0) begin numFails++; $display("[TB] FAIL bp_idle_busy got %b want 0", busy); end
    // Bits without start in IDLE are ignored.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    numChecks++;
    if (busy !== 1'b0 || q_valid !== 1'b0) begin
      numFails++;
      $display("[TB] FAIL idle_ignore busy=%b q_valid=%b want 0 0", busy, q_valid);
    end
  endtask

  // 37 all-ones LSB-first bits, then restart MSB-first with dataC.
  task automatic test_restart();
    pulseReset();
    for (int i = 0; i < 37; i++) begin
      applyStimulus(i == 0, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < W; i++) begin
      applyStimulus(i == 0, 1'b1, dataC[W-1-i], 1'b1, 1'b0);
      if (q_valid !== 1'b0) begin
        numChecks++; numFails++;
        $display("[TB] FAIL restart_early_valid bit %0d got %b want 0", i, q_valid);
      end
    end
`ifdef SHIFT_RX_PARITY_EN
    applyStimulus(1'b0, 1'b0, ^dataC, 1'b1, 1'b0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    numChecks++;
    if (q_valid !== 1'b1) begin numFails++; $display("[TB] FAIL restart_q_valid got %b want 1", q_valid); end
    numChecks++;
    if (q !== dataC) begin numFails++; $display("[TB] FAIL restart_q got %h want %h", q, dataC); end
  endtask

  // Word held; drop a bit, then start a frame in the transfer cycle and reset at bit 50.
  task automatic test_back_to_back_and_async_reset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    numChecks++;
    if (overrun !== 1'b1) begin numFails++; $display("[TB] FAIL b2b_overrun got %b want 1", overrun); end
    for (int i = 0; i < 50; i++) begin
      applyStimulus(i == 0, 1'b0, dataA[i], 1'b1, i == 0);
      if (i == 1) begin
        numChecks++;
        if (q_valid !== 1'b0 || busy !== 1'b1) begin
          numFails++;
          $display("[TB] FAIL b2b_restart q_valid=%b busy=%b want 0 1", q_valid, busy);
        end
      end
    end
    @(posedge clk);
    #3;
    areset = 1'b1;
    #1;
    numChecks++;
    if (q !== '0) begin numFails++; $display("[TB] FAIL areset_q got %h want 0", q); end
    numChecks++;
    if (q_valid !== 1'b0) begin numFails++; $display("[TB] FAIL areset_q_valid got %b want 0", q_valid); end
    numChecks++;
    if (busy !== 1'b0) begin numFails++; $display("[TB] FAIL areset_busy got %b want 0", busy); end
    numChecks++;
    if (overrun !== 1'b0) begin numFails++; $display("[TB] FAIL areset_overrun got %b want 0", overrun); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    areset = 1'b0;
  endtask

`ifdef SHIFT_RX_PARITY_EN
  // Word with three ones: parity bit 1 is correct, parity bit 0 is an error.
  task automatic test_parity();
    logic [W-1:0] word;
    logic         expErr;
    word = {1'b1, 93'b0, 6'b100001};
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < W; i++) begin
        applyStimulus(i == 0, 1'b0, word[i], 1'b1, 1'b0);
      end
      applyStimulus(1'b0, 1'b0, (p == 0), 1'b1, 1'b0);
      expErr = (p == 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      numChecks++;
      if (q_valid !== 1'b1 || parity_err !== expErr) begin
        numFails++;
        $display("[TB] FAIL parity_%0d q_valid=%b parity_err=%b want 1 %b", p, q_valid, parity_err, expErr);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_backpressure();
    test_restart();
    test_back_to_back_and_async_reset();
`ifdef SHIFT_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
